// File: rtl/risc_ctrl_pkg.sv
// Shared encodings for the multicycle RISC control unit: FSM states,
// instruction opcodes, ALU operand-B mux selects and ALU operations.
package risc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_EXEC_LHI = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  typedef enum logic [3:0] {
    OPC_ADD  = 4'h0,
    OPC_ADDI = 4'h1,
    OPC_SUB  = 4'h2,
    OPC_AND  = 4'h3,
    OPC_OR   = 4'h4,
    OPC_LW   = 4'h5,
    OPC_SW   = 4'h6,
    OPC_BEQ  = 4'h7,
    OPC_JMP  = 4'h8,
    OPC_LHI  = 4'h9,
    OPC_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    SRCB_B      = 3'b000,
    SRCB_ONE    = 3'b001,
    SRCB_SEXT6  = 3'b010,
    SRCB_ZEXT8  = 3'b011,
    SRCB_SEXT9  = 3'b100,
    SRCB_SEXT12 = 3'b101,
    SRCB_LHI    = 3'b110,
    SRCB_ZERO   = 3'b111
  } srcb_t;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'b000,
    ALU_SUB    = 3'b001,
    ALU_AND    = 3'b010,
    ALU_OR     = 3'b011,
    ALU_PASS_B = 3'b100
  } alu_op_t;

  // ALU operation for the register-register instructions.
  function automatic alu_op_t rtype_alu_op(input logic [3:0] opc);
    case (opc)
      OPC_SUB: return ALU_SUB;
      OPC_AND: return ALU_AND;
      OPC_OR:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for mem_ready; timeout is high once the
// count has reached WAIT_MAX. The count holds at WAIT_MAX until cleared.
module mem_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(WAIT_MAX);

  logic [7:0] cnt_q, cnt_d;

  // Next count: clear has priority, otherwise count up to the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (cnt_q == LIMIT);

endmodule

// File: rtl/control_fsm_multicycle.sv
// Multicycle control unit for the 16-bit RISC datapath.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instruction at PC, load IR and PC+1 on mem_ready
// DECODE   | branch target precompute into ALUOut, dispatch on opcode
// EXEC_R   | A op B for ADD/SUB/AND/OR
// EXEC_I   | A + sext(ir[5:0]) for ADDI
// EXEC_LHI | pass {ir[7:0],8'h00}
// MEM_ADDR | effective address A + sext(ir[5:0]) for LW/SW
// MEM_RD   | data read at ALUOut, wait for mem_ready
// MEM_WR   | data write at ALUOut, wait for mem_ready
// WB_ALU   | register write from ALUOut
// WB_MEM   | register write from MDR
// BRANCH   | compare A-B, load PC from ALUOut when zero
// JUMP     | PC <= PC + sext(ir[11:0])
// HALT     | stopped; left only through rst
module control_fsm_multicycle
  import risc_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_srcA,
  output logic [2:0] alu_srcB,
  output logic [2:0] alu_op,
  output logic       halted,
  output logic       bus_error,
  output logic [3:0] state
);

  state_t state_q, state_d;
  logic   bus_error_q, bus_error_d;
  logic   in_mem;
  logic   timeout;
  logic   mem_fail;
  logic   tmr_clear;

  assign in_mem    = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign mem_fail  = in_mem && timeout && !mem_ready;
  // A state change also clears, so each new access starts from zero.
  assign tmr_clear = !in_mem || mem_ready || (state_d != state_q);

  mem_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (in_mem),
    .timeout(timeout)
  );

  // Next-state and sticky bus-error decision.
  always_comb begin
    state_d     = state_q;
    bus_error_d = bus_error_q | mem_fail;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)     state_d = S_DECODE;
        else if (mem_fail) state_d = S_HALT;
      end
      S_DECODE: begin
        case (opcode)
          OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: state_d = S_EXEC_R;
          OPC_ADDI:                          state_d = S_EXEC_I;
          OPC_LW, OPC_SW:                    state_d = S_MEM_ADDR;
          OPC_BEQ:                           state_d = S_BRANCH;
          OPC_JMP:                           state_d = S_JUMP;
          OPC_LHI:                           state_d = S_EXEC_LHI;
          OPC_HALT:                          state_d = S_HALT;
          default:                           state_d = S_FETCH;
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_EXEC_LHI: state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (opcode == OPC_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)     state_d = S_WB_MEM;
        else if (mem_fail) state_d = S_HALT;
      end
      S_MEM_WR: begin
        if (mem_ready)     state_d = S_FETCH;
        else if (mem_fail) state_d = S_HALT;
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // State and bus-error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Output decode; while rst is high everything sits at its idle value so
  // an abandoned access never issues a write in the reset cycle.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 2'b10;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_srcA   = 1'b0;
    alu_srcB   = SRCB_ONE;
    alu_op     = ALU_ADD;
    halted     = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = 2'b00;
          end
        end
        S_DECODE: alu_srcB = SRCB_SEXT9;
        S_EXEC_R: begin
          alu_srcA = 1'b1;
          alu_srcB = SRCB_B;
          alu_op   = rtype_alu_op(opcode);
        end
        S_EXEC_I, S_MEM_ADDR: begin
          alu_srcA = 1'b1;
          alu_srcB = SRCB_SEXT6;
        end
        S_EXEC_LHI: begin
          alu_srcB = SRCB_LHI;
          alu_op   = ALU_PASS_B;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_WB_ALU: reg_write = 1'b1;
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          alu_srcA = 1'b1;
          alu_srcB = SRCB_B;
          alu_op   = ALU_SUB;
          pc_src   = 2'b01;
          pc_write = zero;
        end
        S_JUMP: begin
          alu_srcB = SRCB_SEXT12;
          pc_src   = 2'b00;
          pc_write = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus_error = bus_error_q;
  assign state     = state_q;

endmodule

// File: tb/tb_control_fsm_multicycle.sv
// Scoreboard bench for control_fsm_multicycle: an instruction-level model
// expands each instruction into its expected per-cycle output records,
// and a monitor compares them against the DUT on the falling edge.
module tb_control_fsm_multicycle;
  import risc_ctrl_pkg::*;

  localparam int WM = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write;
  logic       mem_to_reg, alu_srcA, halted, bus_error;
  logic [1:0] pc_src;
  logic [2:0] alu_srcB, alu_op;
  logic [3:0] state;

  control_fsm_multicycle #(.WAIT_MAX(WM)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
    .alu_op(alu_op), .halted(halted), .bus_error(bus_error), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic [1:0] pcs;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rgw;
    logic       m2r;
    logic       sa;
    logic [2:0] sb;
    logic [2:0] op;
    logic       hlt;
    logic       berr;
  } rec_t;

  typedef struct packed {
    rec_t e;
    rec_t m;
  } item_t;

  localparam rec_t FULL = '1;

  item_t      sb_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  logic       berr_m = 1'b0;
  logic [3:0] cur_opc = 4'h0;
  int         cyc = 0;

  function automatic rec_t base(input logic [3:0] st);
    rec_t r;
    r      = '0;
    r.st   = st;
    r.pcs  = 2'b10;
    r.sb   = 3'b001;
    r.op   = 3'b000;
    r.berr = berr_m;
    return r;
  endfunction

  function automatic rec_t enables_mask();
    rec_t r;
    r     = '0;
    r.st  = 4'hF;
    r.pcw = 1'b1;
    r.mrd = 1'b1;
    r.mwr = 1'b1;
    r.irw = 1'b1;
    r.rgw = 1'b1;
    return r;
  endfunction

  function automatic logic noise();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return $urandom_range(0, 2);
    if (r < 8) return $urandom_range(3, WM - 1);
    if (r == 8) return WM;
    return WM + 1;
  endfunction

  // One clock cycle: drive the inputs and queue the expected outputs.
  task automatic step(input logic r_i, input logic rdy, input logic z,
                      input rec_t e, input rec_t m);
    item_t it;
    @(posedge clk);
    #1;
    rst       = r_i;
    mem_ready = rdy;
    zero      = z;
    opcode    = cur_opc;
    it.e      = e;
    it.m      = m;
    sb_q.push_back(it);
  endtask

  // Memory wait: res 0 = completed, 1 = timed out, 2 = aborted by reset.
  task automatic mem_phase(input logic [3:0] st, input int d, input int abort_at,
                           output int res);
    rec_t r;
    res = 1;
    for (int c = 0; c <= WM; c++) begin
      if (c == abort_at) begin
        r = base(st);
        step(1'b1, noise(), noise(), r, enables_mask());
        berr_m = 1'b0;
        res = 2;
        return;
      end
      r = base(st);
      if (st == S_FETCH) begin
        r.mrd = 1'b1;
      end else if (st == S_MEM_RD) begin
        r.mrd  = 1'b1;
        r.iord = 1'b1;
      end else begin
        r.mwr  = 1'b1;
        r.iord = 1'b1;
      end
      if (c == d) begin
        if (st == S_FETCH) begin
          r.irw = 1'b1;
          r.pcw = 1'b1;
          r.pcs = 2'b00;
        end
        step(1'b0, 1'b1, noise(), r, FULL);
        res = 0;
        return;
      end
      step(1'b0, 1'b0, noise(), r, FULL);
      if (c == WM) begin
        berr_m = 1'b1;
        res = 1;
        return;
      end
    end
  endtask

  task automatic wb(input logic from_mem);
    rec_t r;
    r     = base(from_mem ? S_WB_MEM : S_WB_ALU);
    r.rgw = 1'b1;
    r.m2r = from_mem;
    step(1'b0, noise(), noise(), r, FULL);
  endtask

  // Expand one instruction into its cycles; stopped=1 when it ends in HALT.
  task automatic run_instr(input logic [3:0] opc, input int df, input int dm,
                           input logic zv, input int abort_at, output bit stopped);
    rec_t r;
    int   res;
    stopped = 1'b0;
    cur_opc = opc;
    mem_phase(S_FETCH, df, -1, res);
    if (res == 1) begin
      stopped = 1'b1;
      return;
    end
    r    = base(S_DECODE);
    r.sb = 3'b100;
    step(1'b0, noise(), noise(), r, FULL);
    case (opc)
      4'd0, 4'd2, 4'd3, 4'd4: begin
        r    = base(S_EXEC_R);
        r.sa = 1'b1;
        r.sb = 3'b000;
        r.op = (opc == 4'd2) ? 3'b001 : (opc == 4'd3) ? 3'b010 : (opc == 4'd4) ? 3'b011 : 3'b000;
        step(1'b0, noise(), noise(), r, FULL);
        wb(1'b0);
      end
      4'd1: begin
        r    = base(S_EXEC_I);
        r.sa = 1'b1;
        r.sb = 3'b010;
        step(1'b0, noise(), noise(), r, FULL);
        wb(1'b0);
      end
      4'd9: begin
        r    = base(S_EXEC_LHI);
        r.sb = 3'b110;
        r.op = 3'b100;
        step(1'b0, noise(), noise(), r, FULL);
        wb(1'b0);
      end
      4'd5, 4'd6: begin
        r    = base(S_MEM_ADDR);
        r.sa = 1'b1;
        r.sb = 3'b010;
        step(1'b0, noise(), noise(), r, FULL);
        mem_phase((opc == 4'd5) ? S_MEM_RD : S_MEM_WR, dm, abort_at, res);
        if (res == 1) stopped = 1'b1;
        else if (res == 0 && opc == 4'd5) wb(1'b1);
      end
      4'd7: begin
        r     = base(S_BRANCH);
        r.sa  = 1'b1;
        r.sb  = 3'b000;
        r.op  = 3'b001;
        r.pcs = 2'b01;
        r.pcw = zv;
        step(1'b0, noise(), zv, r, FULL);
      end
      4'd8: begin
        r     = base(S_JUMP);
        r.sb  = 3'b101;
        r.pcs = 2'b00;
        r.pcw = 1'b1;
        step(1'b0, noise(), noise(), r, FULL);
      end
      4'd15: stopped = 1'b1;
      default: ;
    endcase
  endtask

  task automatic halt_cycles(input int n);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r     = base(S_HALT);
      r.hlt = 1'b1;
      step(1'b0, noise(), noise(), r, FULL);
    end
  endtask

  task automatic do_reset(input logic [3:0] prev, input int n);
    step(1'b1, noise(), noise(), base(prev), enables_mask());
    berr_m = 1'b0;
    for (int i = 1; i < n; i++) step(1'b1, noise(), noise(), base(S_FETCH), FULL);
  endtask

  // Monitor: compare one queued expectation per cycle on the falling edge.
  initial begin
    item_t it;
    rec_t  act;
    forever begin
      @(negedge clk);
      cyc++;
      if (sb_q.size() > 0) begin
        it  = sb_q.pop_front();
        act = {state, pc_write, pc_src, iord, mem_read, mem_write, ir_write,
               reg_write, mem_to_reg, alu_srcA, alu_srcB, alu_op, halted, bus_error};
        n_checks++;
        if (((act ^ it.e) & it.m) == '0) begin
          n_pass++;
        end else begin
          $display("FAIL outputs cycle %0d exp_state %0d: got %h expected %h (mask %h)",
                   cyc, it.e.st, 22'(act), 22'(it.e), 22'(it.m));
        end
      end
    end
  end

  initial begin
    bit stopped;
    int abort_at;

    step(1'b1, 1'b0, 1'b0, base(S_FETCH), FULL);
    step(1'b1, 1'b0, 1'b0, base(S_FETCH), FULL);

    run_instr(4'h0, 0, 0, 1'b0, -1, stopped);
    run_instr(4'h5, 0, 3, 1'b0, -1, stopped);
    run_instr(4'h7, 1, 0, 1'b1, -1, stopped);
    run_instr(4'h7, 0, 0, 1'b0, -1, stopped);
    run_instr(4'hA, 0, 0, 1'b0, -1, stopped);
    run_instr(4'h6, 0, 10, 1'b0, 2, stopped);
    run_instr(4'h1, WM, 0, 1'b0, -1, stopped);
    run_instr(4'h0, WM + 1, 0, 1'b0, -1, stopped);
    if (stopped) begin
      halt_cycles(3);
      do_reset(S_HALT, 2);
    end
    run_instr(4'h5, 0, WM + 1, 1'b0, -1, stopped);
    if (stopped) begin
      halt_cycles(2);
      do_reset(S_HALT, 2);
    end
    run_instr(4'h6, 2, WM, 1'b0, -1, stopped);
    run_instr(4'h8, 0, 0, 1'b0, -1, stopped);
    run_instr(4'h9, 0, 0, 1'b0, -1, stopped);
    run_instr(4'h4, 0, 0, 1'b0, -1, stopped);
    run_instr(4'h3, 0, 0, 1'b0, -1, stopped);
    run_instr(4'h2, 0, 0, 1'b0, -1, stopped);
    run_instr(4'hF, 0, 0, 1'b0, -1, stopped);
    if (stopped) begin
      halt_cycles(2);
      do_reset(S_HALT, 2);
    end

    for (int n = 0; n < 150; n++) begin
      abort_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_instr(4'($urandom_range(0, 15)), pick_delay(), pick_delay(), noise(),
                abort_at, stopped);
      if (stopped) begin
        halt_cycles($urandom_range(1, 3));
        do_reset(S_HALT, $urandom_range(1, 2));
      end
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard drain: %0d left, expected 0", sb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
